crossbar_one_in: RTL and testbench

Single-input, N-output routing crossbar: the distribution end of the N-input/one-output selector crossbar. It accepts one val/rdy message stream and steers each message to exactly one of N_OUTPUTS val/rdy output ports, selected by a stored control word. A 2-entry tagged buffer registers the path, so upstream timing is decoupled from downstream ports, and control changes never re-route messages that are already accepted. It sits at the fan-out side of the interconnect, upstream of per-destination queues.

---
 rtl/crossbar_one_in.sv | 97 +++++++++
 tb/tb_crossbar_one_in.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/crossbar_one_in.sv
// Single-input, N-output val/rdy crossbar: each accepted message is buffered in a
// 2-entry FIFO tagged with the select in force at acceptance, then offered to that port only.
module crossbar_one_in #(
  parameter int BIT_WIDTH         = 32,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BIT_WIDTH-1:0]         recv_msg,
  input  logic                         recv_val,
  output logic                         recv_rdy,
  output logic [BIT_WIDTH-1:0]         send_msg [0:N_OUTPUTS-1],
  output logic [N_OUTPUTS-1:0]         send_val,
  input  logic [N_OUTPUTS-1:0]         send_rdy,
  input  logic [CONTROL_BIT_WIDTH-1:0] control,
  input  logic                         control_val,
  output logic                         control_rdy
);

  localparam int SEL_W = $clog2(N_OUTPUTS);

  logic [CONTROL_BIT_WIDTH-1:0] stored_control;
  logic [SEL_W-1:0]             sel;
  logic [BIT_WIDTH-1:0]         buf_msg [0:1];
  logic [SEL_W-1:0]             buf_tag [0:1];
  logic                         head_ptr;
  logic                         tail_ptr;
  logic [1:0]                   count;
  logic                         full;
  logic                         empty;
  logic                         enq;
  logic                         deq;
  logic                         head_hit;
  logic                         head_in_range;
  logic [SEL_W-1:0]             head_tag;

  assign sel         = stored_control[CONTROL_BIT_WIDTH-1 -: SEL_W];
  assign full        = (count == 2'd2);
  assign empty       = (count == 2'd0);
  assign recv_rdy    = reset && !full;
  assign control_rdy = 1'b1;
  assign enq         = recv_val && recv_rdy;
  assign head_tag    = buf_tag[head_ptr];

  generate
    if (CONTROL_BIT_WIDTH > SEL_W) begin : g_ctrl_low
      logic unused_ctrl_bits;
      assign unused_ctrl_bits = ^stored_control[CONTROL_BIT_WIDTH-SEL_W-1:0];
    end
  endgenerate

  // Head stage: broadcast data, single valid; a tag with no matching port is discarded
  always_comb begin
    head_in_range = 1'b0;
    head_hit      = 1'b0;
    send_val      = '0;
    for (int j = 0; j < N_OUTPUTS; j++) begin
      send_msg[j] = buf_msg[head_ptr];
      if (head_tag == SEL_W'(j)) begin
        head_in_range = 1'b1;
        head_hit      = send_rdy[j];
        send_val[j]   = !empty;
      end
    end
  end

  assign deq = !empty && (head_hit || !head_in_range);

  // Buffer stage: control register, FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stored_control <= '0;
      head_ptr       <= 1'b0;
      tail_ptr       <= 1'b0;
      count          <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_msg[i] <= '0;
        buf_tag[i] <= '0;
      end
    end else begin
      if (control_val) stored_control <= control;
      if (enq) begin
        buf_msg[tail_ptr] <= recv_msg;
        buf_tag[tail_ptr] <= sel;
        tail_ptr          <= ~tail_ptr;
      end
      if (deq) head_ptr <= ~head_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_one_in.sv
// Bench for crossbar_one_in: a 4-port and a 3-port instance driven from vector tables,
// with a message scoreboard tracking the expected output order and destination.
module tb_crossbar_one_in;

  typedef struct {
    logic        rv;
    logic [31:0] msg;
    logic        cv;
    logic [31:0] ctl;
    logic [3:0]  rdy;
    logic        exp_rdy;
    logic [3:0]  exp_val;
  } vec_t;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] msg;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4_n, rst3_n;
  logic [31:0] recv_msg4, recv_msg3, control4, control3;
  logic        recv_val4, recv_val3, control_val4, control_val3;
  logic        recv_rdy4, recv_rdy3, control_rdy4, control_rdy3;
  logic [31:0] send_msg4 [0:3];
  logic [31:0] send_msg3 [0:2];
  logic [3:0]  send_val4, send_rdy4;
  logic [2:0]  send_val3, send_rdy3;

  crossbar_one_in #(.BIT_WIDTH(32), .N_OUTPUTS(4), .CONTROL_BIT_WIDTH(32)) dut4 (
    .clk(clk), .reset(rst4_n),
    .recv_msg(recv_msg4), .recv_val(recv_val4), .recv_rdy(recv_rdy4),
    .send_msg(send_msg4), .send_val(send_val4), .send_rdy(send_rdy4),
    .control(control4), .control_val(control_val4), .control_rdy(control_rdy4)
  );

  crossbar_one_in #(.BIT_WIDTH(32), .N_OUTPUTS(3), .CONTROL_BIT_WIDTH(32)) dut3 (
    .clk(clk), .reset(rst3_n),
    .recv_msg(recv_msg3), .recv_val(recv_val3), .recv_rdy(recv_rdy3),
    .send_msg(send_msg3), .send_val(send_val3), .send_rdy(send_rdy3),
    .control(control3), .control_val(control_val3), .control_rdy(control_rdy3)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sbq[$];
  logic [1:0] model_sel = 2'd0;
  vec_t v4[$];
  vec_t v4b[$];
  vec_t v3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] msg, input logic cv,
                              input logic [31:0] ctl, input logic [3:0] rdy,
                              input logic er, input logic [3:0] ev);
    vec_t v;
    v.rv = rv; v.msg = msg; v.cv = cv; v.ctl = ctl; v.rdy = rdy;
    v.exp_rdy = er; v.exp_val = ev;
    return v;
  endfunction

  task automatic apply(input int which, input vec_t v);
    logic        rr;
    logic [3:0]  sv;
    logic [31:0] m;
    logic        enq_m, deq_m;
    @(negedge clk);
    cyc++;
    if (which == 4) begin
      recv_val4 = v.rv; recv_msg4 = v.msg; control_val4 = v.cv; control4 = v.ctl;
      send_rdy4 = v.rdy;
    end else begin
      recv_val3 = v.rv; recv_msg3 = v.msg; control_val3 = v.cv; control3 = v.ctl;
      send_rdy3 = v.rdy[2:0];
    end
    #1;
    rr = (which == 4) ? recv_rdy4 : recv_rdy3;
    sv = (which == 4) ? send_val4 : {1'b0, send_val3};
    check($sformatf("recv_rdy_n%0d", which), {31'd0, rr}, {31'd0, v.exp_rdy});
    check($sformatf("send_val_n%0d", which), {28'd0, sv}, {28'd0, v.exp_val});
    if (sbq.size() > 0) begin
      if (int'(sbq[0].port) < which) begin
        m = (which == 4) ? send_msg4[sbq[0].port] : send_msg3[sbq[0].port];
        check($sformatf("send_msg_n%0d_p%0d", which, sbq[0].port), m, sbq[0].msg);
      end
    end
    enq_m = v.rv && (sbq.size() < 2);
    deq_m = 1'b0;
    if (sbq.size() > 0) deq_m = (int'(sbq[0].port) >= which) || v.rdy[sbq[0].port];
    if (deq_m) void'(sbq.pop_front());
    if (enq_m) sbq.push_back('{model_sel, v.msg});
    if (v.cv) model_sel = v.ctl[31:30];
  endtask

  initial begin
    rst4_n = 1'b0; rst3_n = 1'b0;
    recv_val4 = 0; recv_msg4 = 0; control_val4 = 0; control4 = 0; send_rdy4 = 0;
    recv_val3 = 0; recv_msg3 = 0; control_val3 = 0; control3 = 0; send_rdy3 = 0;

    // 4-port: route, back-to-back stream, backpressure, control ordering, fill before reset
    v4.push_back(mk(0, 32'h0,   1, 32'h8000_0000, 4'hF, 1, 4'h0));
    v4.push_back(mk(1, 32'hA5,  0, 32'h0,         4'hF, 1, 4'h0));
    v4.push_back(mk(0, 32'h0,   0, 32'h0,         4'hF, 1, 4'b0100));
    v4.push_back(mk(0, 32'h0,   1, 32'h4000_0000, 4'hF, 1, 4'h0));
    for (int i = 0; i < 8; i++)
      v4.push_back(mk(1, 32'(i), 0, 32'h0, 4'hF, 1, (i == 0) ? 4'h0 : 4'b0010));
    v4.push_back(mk(0, 32'h0,   0, 32'h0,         4'hF, 1, 4'b0010));
    v4.push_back(mk(1, 32'h100, 0, 32'h0,         4'hD, 1, 4'h0));
    v4.push_back(mk(1, 32'h101, 0, 32'h0,         4'hD, 1, 4'b0010));
    v4.push_back(mk(1, 32'h102, 0, 32'h0,         4'hD, 0, 4'b0010));
    v4.push_back(mk(1, 32'h102, 0, 32'h0,         4'hD, 0, 4'b0010));
    v4.push_back(mk(1, 32'h102, 0, 32'h0,         4'hF, 0, 4'b0010));
    v4.push_back(mk(1, 32'h102, 0, 32'h0,         4'hF, 1, 4'b0010));
    v4.push_back(mk(0, 32'h0,   0, 32'h0,         4'hF, 1, 4'b0010));
    v4.push_back(mk(0, 32'h0,   1, 32'h0,         4'hF, 1, 4'h0));
    v4.push_back(mk(1, 32'h11,  0, 32'h0,         4'hF, 1, 4'h0));
    v4.push_back(mk(1, 32'h22,  1, 32'hC000_0000, 4'hF, 1, 4'b0001));
    v4.push_back(mk(1, 32'h33,  0, 32'h0,         4'hF, 1, 4'b0001));
    v4.push_back(mk(0, 32'h0,   0, 32'h0,         4'hF, 1, 4'b1000));
    v4.push_back(mk(0, 32'h0,   0, 32'h0,         4'hF, 1, 4'h0));
    v4.push_back(mk(1, 32'h55,  0, 32'h0,         4'h0, 1, 4'h0));
    v4.push_back(mk(1, 32'h66,  0, 32'h0,         4'h0, 1, 4'b1000));
    v4.push_back(mk(0, 32'h0,   0, 32'h0,         4'h0, 0, 4'b1000));

    // 4-port after mid-stream reset: empty, ready, select back to port 0
    v4b.push_back(mk(0, 32'h0,  0, 32'h0, 4'hF, 1, 4'h0));
    v4b.push_back(mk(1, 32'h77, 0, 32'h0, 4'hF, 1, 4'h0));
    v4b.push_back(mk(0, 32'h0,  0, 32'h0, 4'hF, 1, 4'b0001));
    v4b.push_back(mk(0, 32'h0,  0, 32'h0, 4'hF, 1, 4'h0));

    // 3-port: out-of-range select drops 0x44, then 0x55 to port 0
    v3.push_back(mk(0, 32'h0,  1, 32'hC000_0000, 4'h7, 1, 4'h0));
    v3.push_back(mk(1, 32'h44, 0, 32'h0,         4'h7, 1, 4'h0));
    v3.push_back(mk(0, 32'h0,  1, 32'h0,         4'h7, 1, 4'h0));
    v3.push_back(mk(1, 32'h55, 0, 32'h0,         4'h7, 1, 4'h0));
    v3.push_back(mk(0, 32'h0,  0, 32'h0,         4'h7, 1, 4'b001));
    v3.push_back(mk(0, 32'h0,  0, 32'h0,         4'h7, 1, 4'h0));

    #3;
    check("rst_send_val_n4", {28'd0, send_val4}, 32'd0);
    check("rst_recv_rdy_n4", {31'd0, recv_rdy4}, 32'd0);
    check("rst_ctrl_rdy_n4", {31'd0, control_rdy4}, 32'd1);
    for (int j = 0; j < 4; j++) check($sformatf("rst_send_msg_n4_p%0d", j), send_msg4[j], 32'd0);
    check("rst_send_val_n3", {29'd0, send_val3}, 32'd0);
    check("rst_recv_rdy_n3", {31'd0, recv_rdy3}, 32'd0);
    check("rst_ctrl_rdy_n3", {31'd0, control_rdy3}, 32'd1);
    #9;
    rst4_n = 1'b1; rst3_n = 1'b1;

    for (int i = 0; i < v4.size(); i++) apply(4, v4[i]);

    // Asynchronous reset pulse between edges with two entries buffered
    #1 rst4_n = 1'b0;
    #1;
    check("async_send_val_n4", {28'd0, send_val4}, 32'd0);
    check("async_send_msg_n4_p3", send_msg4[3], 32'd0);
    check("async_recv_rdy_n4", {31'd0, recv_rdy4}, 32'd0);
    #1 rst4_n = 1'b1;
    sbq.delete();
    model_sel = 2'd0;

    for (int i = 0; i < v4b.size(); i++) apply(4, v4b[i]);

    sbq.delete();
    model_sel = 2'd0;
    for (int i = 0; i < v3.size(); i++) apply(3, v3[i]);

    check("sb_empty_at_end", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
